// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   // Oversample counter positions within one 16-tick bit cell
   localparam logic [3:0] SAMP_FIRST = 4'd7;
   localparam logic [3:0] SAMP_MID   = 4'd8;
   localparam logic [3:0] SAMP_LAST  = 4'd9;
   localparam logic [3:0] SAMP_END   = 4'd15;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop metastability synchroniser for the asynchronous rx pin; resets to idle-high.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the raw pin through the flop chain every clk
   always_ff @(posedge clk) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
   end

   assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// 16x-oversampling UART receiver with 3-sample majority vote and a read handshake.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_clock,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       rx,
   input  logic       read_rx_byte,
   output logic [7:0] rx_byte,
   output logic       rx_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow,
   output logic       rx_idle
);

   rx_state_t  state_q, state_d;
   logic       rx_s;
   logic [3:0] samp_cnt_q;
   logic [1:0] samp_q;          // samples taken at SAMP_FIRST and SAMP_MID
   logic [2:0] bit_cnt_q;
   logic [7:0] data_q;
   logic       bit8_q, pen_q, odd_q;
   logic       perr_q;
   logic       armed_q;
   logic [7:0] rx_byte_q;
   logic       rx_ready_q, parity_err_q, framing_err_q, overflow_q;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (rx),
      .sync_o  (rx_s)
   );

   logic at_last, at_end, vote, last_bit, start_det, commit;
   assign at_last   = (samp_cnt_q == SAMP_LAST);
   assign at_end    = (samp_cnt_q == SAMP_END);
   assign vote      = maj3(samp_q[1], samp_q[0], rx_s);
   assign last_bit  = bit8_q ? (bit_cnt_q == 3'd7) : (bit_cnt_q == 3'd6);
   assign start_det = baud_clock && (state_q == IDLE) && !rx_s && armed_q;
   assign commit    = baud_clock && (state_q == STOP) && at_last;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: decisions at the vote point, bit-cell moves at the cell end
   always_comb begin
      state_d = state_q;
      if (baud_clock) begin
         unique case (state_q)
            IDLE:   if (!rx_s && armed_q) state_d = START;
            START:  if (at_last && vote) state_d = IDLE;
                    else if (at_end)     state_d = DATA;
            DATA:   if (at_end && last_bit) state_d = pen_q ? PARITY : STOP;
            PARITY: if (at_end) state_d = STOP;
            STOP:   if (at_last) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      rx_idle = (state_q == IDLE);
   end

   // Oversampling, data assembly, parity and break-arming; all gated by the baud tick
   always_ff @(posedge clk) begin
      if (reset) begin
         samp_cnt_q <= '0;
         samp_q     <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         bit8_q     <= 1'b0;
         pen_q      <= 1'b0;
         odd_q      <= 1'b0;
         perr_q     <= 1'b0;
         armed_q    <= 1'b1;
      end else if (baud_clock) begin
         samp_cnt_q <= (state_q == IDLE) ? 4'd0 : samp_cnt_q + 4'd1;
         if (samp_cnt_q == SAMP_FIRST || samp_cnt_q == SAMP_MID)
            samp_q <= {samp_q[0], rx_s};
         if (start_det) begin
            // Frame format is frozen for the whole frame at start
            bit8_q    <= bit8;
            pen_q     <= parity_en;
            odd_q     <= odd_n_even;
            data_q    <= '0;
            bit_cnt_q <= '0;
            perr_q    <= 1'b0;
         end
         if (state_q == DATA && at_last) data_q[bit_cnt_q] <= vote;
         if (state_q == DATA && at_end && !last_bit) bit_cnt_q <= bit_cnt_q + 3'd1;
         if (state_q == PARITY && at_last) perr_q <= ((^data_q) ^ vote) != odd_q;
         // A low stop bit disarms start detection until the line returns high
         if (commit && !vote) armed_q <= 1'b0;
         else if (rx_s)       armed_q <= 1'b1;
      end
   end

   // Output byte register and consumer handshake; a commit beats a same-cycle read
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_byte_q     <= '0;
         rx_ready_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else if (commit) begin
         rx_byte_q     <= data_q;
         rx_ready_q    <= 1'b1;
         parity_err_q  <= pen_q & perr_q;
         framing_err_q <= ~vote;
         if (rx_ready_q && !read_rx_byte) overflow_q <= 1'b1;
      end else if (read_rx_byte && rx_ready_q) begin
         rx_ready_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overflow_q    <= 1'b0;
      end
   end

   assign rx_byte     = rx_byte_q;
   assign rx_ready    = rx_ready_q;
   assign parity_err  = parity_err_q;
   assign framing_err = framing_err_q;
   assign overflow    = overflow_q;

endmodule
